// File: rtl/adc_sample_sched_if.sv
// adc_sample_sched_if
// Bundles the two handshakes of the sample scheduler:
//   ADC side      : adc_start (pulse out), adc_done / adc_data (result in)
//   consumer side : smp_valid / smp_data (out), smp_ready (in)
// master modport is the scheduler; slave modport is the ADC plus consumer.
interface adc_sample_sched_if #(
  parameter int DATA_W = 12
);
  logic              adc_start;
  logic              adc_done;
  logic [DATA_W-1:0] adc_data;
  logic              smp_valid;
  logic [DATA_W-1:0] smp_data;
  logic              smp_ready;

  modport master (
    output adc_start,
    input  adc_done,
    input  adc_data,
    output smp_valid,
    output smp_data,
    input  smp_ready
  );

  modport slave (
    input  adc_start,
    output adc_done,
    output adc_data,
    input  smp_valid,
    input  smp_data,
    output smp_ready
  );
endinterface

// File: rtl/adc_sample_sched.sv
// adc_sample_sched
// Runs ADC conversions at a programmed period, sums 2^avg_log2 results and
// hands the truncated average to the consumer through a one-entry
// valid/ready buffer. Lost ticks and overwritten results set a sticky flag.
// Ports:
//   PCLK, PRESETn  clock, asynchronous active-low reset
//   sample_enable  run/stop of sequencing
//   period         tick interval minus one (PCLK cycles)
//   avg_log2       log2 of samples per output (latched at block start)
//   bus            ADC start/done/data and smp_valid/data/ready handshakes
//   overrun        sticky tick/result loss, cleared by overrun_clr
//   busy           conversion in flight
module adc_sample_sched #(
  parameter int DATA_W   = 12,
  parameter int PERIOD_W = 16,
  parameter int AVG_W    = 3
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                sample_enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [AVG_W-1:0]    avg_log2,
  adc_sample_sched_if.master  bus,
  output logic                overrun,
  input  logic                overrun_clr,
  output logic                busy
);

  localparam int CNT_W = 1 << AVG_W;
  localparam int ACC_W = DATA_W + CNT_W - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_PUSH
  } state_t;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [AVG_W-1:0]    avg_lat_q, avg_lat_d;
  logic                abort_q, abort_d;
  logic                adc_start_q, adc_start_d;
  logic                smp_valid_q, smp_valid_d;
  logic [DATA_W-1:0]   smp_data_q, smp_data_d;
  logic                overrun_q, overrun_d;

  logic                tick;
  logic                drop_tick;
  logic                lost_result;
  logic                aborting;
  logic                load;
  logic [DATA_W-1:0]   result;
  logic [CNT_W-1:0]    count_inc;

  // Tick counter: free-runs while enabled. Lowering period below the
  // current count lets it run on through the natural wrap.
  always_comb begin
    tick  = 1'b0;
    cnt_d = '0;
    if (sample_enable) begin
      if (cnt_q == period) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + PERIOD_W'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    avg_lat_d   = avg_lat_q;
    abort_d     = abort_q;
    adc_start_d = 1'b0;
    drop_tick   = 1'b0;
    aborting    = abort_q | ~sample_enable;
    count_inc   = count_q + CNT_W'(1);
    load        = (state_q == S_PUSH);
    result      = DATA_W'(acc_q >> avg_lat_q);

    case (state_q)
      S_IDLE: begin
        if (!sample_enable) begin
          acc_d   = '0;
          count_d = '0;
        end else if (tick) begin
          adc_start_d = 1'b1;
          state_d     = S_CONV;
          if (count_q == '0) begin
            avg_lat_d = avg_log2;
          end
        end
      end
      S_CONV: begin
        drop_tick = tick;
        // A disable seen at any point of the conversion is remembered so
        // the eventual result is discarded even if enable comes back.
        abort_d   = aborting;
        if (bus.adc_done) begin
          abort_d = 1'b0;
          state_d = S_IDLE;
          if (aborting) begin
            acc_d   = '0;
            count_d = '0;
          end else begin
            acc_d   = acc_q + ACC_W'(bus.adc_data);
            count_d = count_inc;
            if (count_inc == (CNT_W'(1) << avg_lat_q)) begin
              state_d = S_PUSH;
            end
          end
        end
      end
      S_PUSH: begin
        drop_tick = tick;
        acc_d     = '0;
        count_d   = '0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Single-entry output buffer; a load always wins over consumption.
  always_comb begin
    smp_valid_d = smp_valid_q;
    smp_data_d  = smp_data_q;
    lost_result = 1'b0;
    if (load) begin
      smp_valid_d = 1'b1;
      smp_data_d  = result;
      lost_result = smp_valid_q & ~bus.smp_ready;
    end else if (smp_valid_q && bus.smp_ready) begin
      smp_valid_d = 1'b0;
    end

    if (drop_tick || lost_result) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      avg_lat_q   <= '0;
      abort_q     <= 1'b0;
      adc_start_q <= 1'b0;
      smp_valid_q <= 1'b0;
      smp_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      avg_lat_q   <= avg_lat_d;
      abort_q     <= abort_d;
      adc_start_q <= adc_start_d;
      smp_valid_q <= smp_valid_d;
      smp_data_q  <= smp_data_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.adc_start = adc_start_q;
  assign bus.smp_valid = smp_valid_q;
  assign bus.smp_data  = smp_data_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q == S_CONV);

endmodule

// File: tb/tb_adc_sample_sched.sv
// tb_adc_sample_sched
// Directed bench for adc_sample_sched. A transaction-level model (sample
// list, integer average) predicts every output each cycle; directed steps
// add literal expectations for latency, averages and overrun behaviour.
module tb_adc_sample_sched;

  logic        PCLK;
  logic        PRESETn;
  logic        sample_enable;
  logic [15:0] period;
  logic [2:0]  avg_log2;
  logic        overrun;
  logic        overrun_clr;
  logic        busy;

  adc_sample_sched_if #(.DATA_W(12)) bus ();

  adc_sample_sched #(
    .DATA_W   (12),
    .PERIOD_W (16),
    .AVG_W    (3)
  ) dut (
    .PCLK          (PCLK),
    .PRESETn       (PRESETn),
    .sample_enable (sample_enable),
    .period        (period),
    .avg_log2      (avg_log2),
    .bus           (bus),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr),
    .busy          (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic go(int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // ADC responder: answers each start after resp_delay cycles.
  logic [11:0] data_q[$];
  logic [11:0] resp_default = 12'h123;
  int          resp_delay   = 3;
  int          resp_cnt     = 0;

  initial begin
    bus.adc_done = 1'b0;
    bus.adc_data = '0;
    forever begin
      @(posedge PCLK);
      #1;
      bus.adc_done = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          bus.adc_done = 1'b1;
          if (data_q.size() > 0) bus.adc_data = data_q.pop_front();
          else                   bus.adc_data = resp_default;
        end
      end
      if (bus.adc_start) resp_cnt = resp_delay;
    end
  end

  // Activity monitor for the literal expectations.
  int          start_count = 0;
  int          valid_count = 0;
  int          last_valid_data = 0;

  initial begin
    forever begin
      @(negedge PCLK);
      if (bus.adc_start) start_count++;
      if (bus.smp_valid) begin
        valid_count++;
        last_valid_data = int'(bus.smp_data);
      end
    end
  end

  // Behavioural model: phase flags, a list of collected samples and the
  // expected output registers.
  int m_cnt     = 0;
  bit m_conv    = 0;
  bit m_push    = 0;
  bit m_abort   = 0;
  int m_avg     = 0;
  int m_samples[$];
  bit e_start   = 0;
  bit e_valid   = 0;
  int e_data    = 0;
  bit e_overrun = 0;

  task automatic model_step();
    bit tk, idle, drop, lost, ab;
    int sum, res;
    if (!PRESETn) begin
      m_cnt = 0; m_conv = 0; m_push = 0; m_abort = 0; m_avg = 0;
      m_samples.delete();
      e_start = 0; e_valid = 0; e_data = 0; e_overrun = 0;
      return;
    end
    tk   = sample_enable && (m_cnt == int'(period));
    idle = !m_conv && !m_push;
    drop = tk && !idle;
    lost = 0;
    if (!sample_enable || tk) m_cnt = 0;
    else                      m_cnt = (m_cnt + 1) % 65536;

    if (m_push) begin
      sum = 0;
      foreach (m_samples[i]) sum += m_samples[i];
      res = (sum / (1 << m_avg)) % 4096;
      lost = e_valid && !bus.smp_ready;
      e_valid = 1;
      e_data  = res;
    end else if (e_valid && bus.smp_ready) begin
      e_valid = 0;
    end
    if (drop || lost)     e_overrun = 1;
    else if (overrun_clr) e_overrun = 0;
    e_start = idle && tk;

    if (m_push) begin
      m_samples.delete();
      m_push = 0;
    end else if (m_conv) begin
      ab = m_abort || !sample_enable;
      m_abort = ab;
      if (bus.adc_done) begin
        m_abort = 0;
        m_conv  = 0;
        if (ab) m_samples.delete();
        else begin
          m_samples.push_back(int'(bus.adc_data));
          if (m_samples.size() == (1 << m_avg)) m_push = 1;
        end
      end
    end else begin
      if (!sample_enable) m_samples.delete();
      else if (tk) begin
        if (m_samples.size() == 0) m_avg = int'(avg_log2);
        m_conv = 1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge PCLK or negedge PRESETn);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge PCLK);
      check("adc_start", int'(bus.adc_start), int'(e_start));
      check("busy",      int'(busy),          int'(m_conv));
      check("smp_valid", int'(bus.smp_valid), int'(e_valid));
      check("smp_data",  int'(bus.smp_data),  e_data);
      check("overrun",   int'(overrun),       int'(e_overrun));
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      go(1);
      n++;
    end
    check("wait_idle_busy", int'(busy), 0);
    go(2);
  endtask

  task automatic clear_overrun();
    overrun_clr = 1'b1;
    go(1);
    overrun_clr = 1'b0;
    go(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    PRESETn       = 1'b0;
    sample_enable = 1'b0;
    period        = 16'd9;
    avg_log2      = 3'd0;
    overrun_clr   = 1'b0;
    bus.smp_ready = 1'b1;
    go(2);
    check("rst_adc_start", int'(bus.adc_start), 0);
    check("rst_smp_valid", int'(bus.smp_valid), 0);
    check("rst_smp_data",  int'(bus.smp_data),  0);
    check("rst_overrun",   int'(overrun),       0);
    check("rst_busy",      int'(busy),          0);
    PRESETn = 1'b1;
    go(1);

    // Single-sample path, period 10, done 3 cycles after start.
    data_q.delete();
    resp_delay    = 3;
    sample_enable = 1'b1;
    start_count   = 0;
    valid_count   = 0;
    go(10);
    check("t1_first_start", int'(bus.adc_start), 1);
    go(5);
    check("t1_valid_lat", int'(bus.smp_valid), 1);
    check("t1_data",      int'(bus.smp_data),  'h123);
    go(85);
    check("t1_starts",  start_count, 9);
    check("t1_outputs", valid_count, 9);
    check("t1_overrun", int'(overrun), 0);
    sample_enable = 1'b0;
    wait_idle();

    // Four-sample average.
    avg_log2 = 3'd2;
    data_q   = '{12'h100, 12'h101, 12'h102, 12'h105};
    sample_enable = 1'b1;
    start_count   = 0;
    valid_count   = 0;
    go(46);
    check("t2_starts",  start_count, 4);
    check("t2_outputs", valid_count, 1);
    check("t2_avg",     last_valid_data, 'h102);
    sample_enable = 1'b0;
    wait_idle();

    // Period shorter than conversion time.
    avg_log2   = 3'd0;
    period     = 16'd1;
    resp_delay = 5;
    sample_enable = 1'b1;
    go(10);
    check("t3_drop_overrun", int'(overrun), 1);
    sample_enable = 1'b0;
    wait_idle();
    clear_overrun();
    check("t3_clr_overrun", int'(overrun), 0);
    sample_enable = 1'b1;
    go(5);
    check("t3_overrun_again", int'(overrun), 1);
    overrun_clr = 1'b1;
    go(1);
    overrun_clr = 1'b0;
    check("t3_set_beats_clr", int'(overrun), 1);
    sample_enable = 1'b0;
    wait_idle();
    clear_overrun();

    // Output buffer overwrite, then simultaneous consume and load.
    period        = 16'd9;
    resp_delay    = 3;
    bus.smp_ready = 1'b0;
    data_q        = '{12'h010, 12'h020};
    sample_enable = 1'b1;
    go(26);
    check("t4_overwrite_data",  int'(bus.smp_data),  'h020);
    check("t4_overwrite_valid", int'(bus.smp_valid), 1);
    check("t4_overwrite_ovr",   int'(overrun),       1);
    sample_enable = 1'b0;
    go(2);
    overrun_clr   = 1'b1;
    bus.smp_ready = 1'b1;
    go(1);
    overrun_clr   = 1'b0;
    bus.smp_ready = 1'b0;
    go(1);
    check("t4_drained_valid", int'(bus.smp_valid), 0);
    check("t4_drained_ovr",   int'(overrun),       0);
    data_q        = '{12'h030, 12'h040};
    sample_enable = 1'b1;
    go(24);
    bus.smp_ready = 1'b1;
    go(1);
    check("t4_swap_valid", int'(bus.smp_valid), 1);
    check("t4_swap_data",  int'(bus.smp_data),  'h040);
    check("t4_swap_ovr",   int'(overrun),       0);
    sample_enable = 1'b0;
    wait_idle();

    // Disable during a conversion discards the partial block.
    avg_log2      = 3'd1;
    data_q        = '{12'h0AA, 12'h0BB};
    sample_enable = 1'b1;
    valid_count   = 0;
    go(21);
    sample_enable = 1'b0;
    go(5);
    check("t5_abort_busy",    int'(busy), 0);
    check("t5_abort_outputs", valid_count, 0);
    data_q        = '{12'h0F0, 12'h0F2};
    sample_enable = 1'b1;
    valid_count   = 0;
    go(26);
    check("t5_outputs", valid_count, 1);
    check("t5_avg",     last_valid_data, 'h0F1);
    sample_enable = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of a conversion.
    avg_log2      = 3'd0;
    bus.smp_ready = 1'b0;
    data_q        = '{12'h055};
    sample_enable = 1'b1;
    go(21);
    check("t6_pre_busy",  int'(busy),          1);
    check("t6_pre_valid", int'(bus.smp_valid), 1);
    #2;
    PRESETn       = 1'b0;
    sample_enable = 1'b0;
    #1;
    check("t6_rst_adc_start", int'(bus.adc_start), 0);
    check("t6_rst_busy",      int'(busy),          0);
    check("t6_rst_valid",     int'(bus.smp_valid), 0);
    check("t6_rst_data",      int'(bus.smp_data),  0);
    check("t6_rst_overrun",   int'(overrun),       0);
    go(2);
    PRESETn     = 1'b1;
    start_count = 0;
    go(20);
    check("t6_no_start", start_count, 0);
    bus.smp_ready = 1'b1;
    sample_enable = 1'b1;
    go(10);
    check("t6_restart", int'(bus.adc_start), 1);
    sample_enable = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_sample_sched.md
Name: adc_sample_sched

Overview:
- Sequences the 12-bit ADC conversion path at a programmed sample period.
- Issues one-cycle start pulses and waits for conversion-done.
- Accumulates 2^avg_log2 conversions into a truncated average.
- Presents the average to the downstream consumer (PID/TMU path) through a single-entry valid/ready buffer, with sticky overrun reporting. Configuration comes from the APB register block; the block sits between that block and the ADC.

Parameters:
DATA_W, 12, ADC sample width
PERIOD_W, 16, sample-period counter width
AVG_W, 3, width of avg_log2; max oversampling 2^(2^AVG_W-1) = 128

Ports:
PCLK  input  1  clock
PRESETn  input  1  asynchronous active-low reset
sample_enable  input  1  run/stop of sequencing (from APB register)
period  input  PERIOD_W  tick interval minus one, in PCLK cycles
avg_log2  input  AVG_W  log2 of samples averaged per output
adc_start  output  1  one-cycle conversion start pulse
adc_done  input  1  one-cycle conversion-complete strobe
adc_data  input  DATA_W  conversion result, valid with adc_done
smp_valid  output  1  averaged sample available
smp_data  output  DATA_W  averaged sample
smp_ready  input  1  consumer accepts when smp_valid & smp_ready
overrun  output  1  sticky: tick or result lost
overrun_clr  input  1  clears overrun
busy  output  1  high in CONV state

Behaviour:
- Reset: all outputs 0; state IDLE; tick counter, accumulator and sample count all 0.
- Tick counter:
  - Runs only while sample_enable=1; otherwise held at 0.
  - tick=1 when cnt==period, then cnt wraps to 0. period=0 gives a tick every cycle.
  - period is sampled live; if it is lowered below cnt, cnt wraps at 2^PERIOD_W-1.
- States:
  - IDLE: on tick, adc_start=1 for exactly one cycle and go to CONV. If the sample count is 0, latch avg_log2 into avg_lat; later avg_log2 changes take effect at the next block.
  - CONV: busy=1; wait for adc_done.
    - On adc_done: acc += adc_data (accumulator width DATA_W+2^AVG_W-1), count += 1.
    - If count reaches 2^avg_lat: go to PUSH. Otherwise go to IDLE.
  - PUSH (one cycle): result = acc >> avg_lat (truncating, DATA_W bits); clear acc and count; go to IDLE.
- Latency: adc_done in cycle t that completes a block gives smp_valid=1 with new smp_data in cycle t+2.
- Output buffer:
  - When result loads: smp_valid=1, smp_data=result.
  - smp_valid & smp_ready clears smp_valid the next cycle.
  - New result while smp_valid=1 and smp_ready=0: overwrite smp_data, keep smp_valid=1, set overrun.
  - New result with smp_ready=1 in the same cycle: old value consumed, new value loaded, smp_valid stays 1, no overrun.
- A tick while in CONV or PUSH is dropped and sets overrun (conversion slower than the period).
- adc_done outside CONV is ignored. No second adc_start is issued while in CONV.
- overrun_clr clears overrun; a set in the same cycle wins.
- sample_enable deassert:
  - From IDLE/PUSH: return to IDLE immediately and clear acc and count. A result computed in PUSH that cycle is still delivered.
  - From CONV: remain in CONV until adc_done, then discard the data, clear acc and count, go to IDLE.
  - The output buffer is unaffected by disable.
- Reset mid-operation: asynchronous return to reset values; any pending smp_valid is lost.

Test Plan:
- period=9, avg_log2=0, done 3 cycles after each start, adc_data=0x123, smp_ready=1 -> adc_start every 10 cycles; smp_valid 2 cycles after each done with smp_data=0x123; overrun stays 0.
- avg_log2=2, data sequence 0x100, 0x101, 0x102, 0x105 -> one output 0x102 (sum 0x408 >> 2); exactly 4 starts per output.
- period=1, done 5 cycles after start -> ticks during CONV dropped, overrun=1. overrun_clr pulse with no new drop -> overrun=0. Clear coincident with a drop -> overrun stays 1.
- smp_ready=0 for two outputs (0x010, 0x020) -> smp_data=0x020, smp_valid=1, overrun=1. Repeat with smp_ready=1 on the load cycle -> overrun=0.
- sample_enable dropped during CONV with avg_log2=1 after one sample -> next done discarded, no smp_valid. Re-enable with data 0x0F0, 0x0F2 -> output 0x0F1.
- Assert PRESETn=0 mid-CONV with smp_valid=1 -> all outputs 0 asynchronously; after release no adc_start until sample_enable and a tick.
